// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding and default bit timing.
package uart_pkg;

  // Frame sequencer states, shared with the receiver
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } uart_state_e;

  // 115200 baud from a 100 MHz clock
  localparam int unsigned CLK_PER_BIT_DEFAULT = 868;

  localparam int unsigned DATA_W = 8;
  localparam int unsigned IDX_W  = 3;

endpackage : uart_pkg

// File: rtl/uart_tx_baud_counter.sv
// Bit-period timer: counts clk cycles within one serial bit and flags the last one.
module uart_baud_counter
  import uart_pkg::*;
#(
  parameter int unsigned CLK_PER_BIT = CLK_PER_BIT_DEFAULT
) (
  input  logic clk,
  input  logic rst_n,
  input  logic reload,
  output logic tick_c
);

  localparam int unsigned           CNT_W = $clog2(CLK_PER_BIT);
  localparam logic [CNT_W-1:0]      LAST  = CNT_W'(CLK_PER_BIT - 1);

  logic [CNT_W-1:0] cnt_q;

  // Restart at each bit boundary (or while idle), otherwise count up
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (reload) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  // High on the final cycle of the current bit
  assign tick_c = (cnt_q == LAST);

endmodule : uart_baud_counter

// File: rtl/uart_tx.sv
// 8N1 UART transmitter with flow-control hold; tx and busy come straight from flops.
module uart_tx
  import uart_pkg::*;
#(
  parameter int unsigned CLK_PER_BIT = CLK_PER_BIT_DEFAULT
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] data,
  input  logic       new_data,
  input  logic       block,
  output logic       tx,
  output logic       busy
);

  uart_state_e       state_q, state_d;
  logic [DATA_W-1:0] shift_q, shift_d;
  logic [IDX_W-1:0]  idx_q,   idx_d;
  logic              tx_d;
  logic              busy_d;
  logic              tick_c;
  logic              reload_c;

  // Bit timer restarts whenever idle so the start bit gets a full period
  assign reload_c = (state_q == IDLE) | tick_c;

  uart_baud_counter #(
    .CLK_PER_BIT (CLK_PER_BIT)
  ) u_baud (
    .clk    (clk),
    .rst_n  (rst_n),
    .reload (reload_c),
    .tick_c (tick_c)
  );

  // State, shift register, bit index and line outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      shift_q <= '0;
      idx_q   <= '0;
      tx      <= 1'b1;
      busy    <= 1'b0;
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      idx_q   <= idx_d;
      tx      <= tx_d;
      busy    <= busy_d;
    end
  end

  // Next-state logic; tx_d is the value the line holds for the coming bit
  always_comb begin
    state_d = state_q;
    shift_d = shift_q;
    idx_d   = idx_q;
    tx_d    = tx;

    unique case (state_q)
      IDLE: begin
        tx_d = 1'b1;
        if (new_data && !block) begin
          state_d = START;
          shift_d = data;
          idx_d   = '0;
          tx_d    = 1'b0;
        end
      end
      START: begin
        if (tick_c) begin
          state_d = DATA;
          tx_d    = shift_q[0];
          shift_d = shift_q >> 1;
        end
      end
      DATA: begin
        if (tick_c) begin
          if (idx_q == IDX_W'(DATA_W - 1)) begin
            state_d = STOP;
            tx_d    = 1'b1;
          end else begin
            idx_d   = idx_q + IDX_W'(1);
            tx_d    = shift_q[0];
            shift_d = shift_q >> 1;
          end
        end
      end
      STOP: begin
        tx_d = 1'b1;
        if (tick_c) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
        tx_d    = 1'b1;
      end
    endcase

    busy_d = (state_d != IDLE) | block;
  end

endmodule : uart_tx

// File: tb/tb_uart_tx.sv
// Scoreboard bench for uart_tx at CLK_PER_BIT=4.
module tb_uart_tx;

  localparam int C = 4;

  logic       clk      = 1'b0;
  logic       rst_n    = 1'b1;
  logic [7:0] data     = 8'h00;
  logic       new_data = 1'b0;
  logic       block    = 1'b0;
  logic       tx;
  logic       busy;

  typedef struct {
    logic [7:0] d;
    int         gap;   // required start-to-start spacing, 0 = don't care
  } exp_t;

  exp_t        q[$];
  int          n_vec = 0;
  int          n_err = 0;
  int unsigned cyc   = 0;
  bit          mon_abort = 1'b0;

  uart_tx #(
    .CLK_PER_BIT (C)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .data     (data),
    .new_data (new_data),
    .block    (block),
    .tx       (tx),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge rst_n) mon_abort = 1'b1;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic send_pulse(input logic [7:0] d);
    data     = d;
    new_data = 1'b1;
    @(negedge clk);
    new_data = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    int n;
    n = 0;
    while (busy !== 1'b0 && n < 500) begin
      @(negedge clk);
      n++;
    end
    check(name, busy, 0);
  endtask

  // Monitor: decode each frame from the line and compare with the scoreboard
  initial begin : monitor
    logic [7:0]  b;
    logic        st;
    logic        sp;
    int unsigned start_cyc;
    int unsigned prev_cyc;
    bit          have_prev;
    int          diff;
    exp_t        e;
    have_prev = 1'b0;
    prev_cyc  = 0;
    forever begin
      @(negedge clk);
      if (rst_n === 1'b1 && tx === 1'b0) begin
        mon_abort = 1'b0;
        start_cyc = cyc;
        repeat (C / 2) @(negedge clk);
        st = tx;
        for (int i = 0; i < 8; i++) begin
          repeat (C) @(negedge clk);
          b[i] = tx;
        end
        repeat (C) @(negedge clk);
        sp = tx;
        if (mon_abort) begin
          mon_abort = 1'b0;
          have_prev = 1'b0;
        end else begin
          diff = int'(start_cyc - prev_cyc);
          n_vec++;
          if (q.size() == 0) begin
            n_err++;
            $display("FAIL frame: unexpected frame data=%02h on tx, expected no frame", b);
          end else begin
            e = q.pop_front();
            if (st !== 1'b0 || sp !== 1'b1 || b !== e.d ||
                (e.gap > 0 && (!have_prev || diff != e.gap))) begin
              n_err++;
              $display("FAIL frame: got data=%02h start=%b stop=%b gap=%0d, expected data=%02h start=0 stop=1 gap=%0d",
                       b, st, sp, diff, e.d, e.gap);
            end
          end
          prev_cyc  = start_cyc;
          have_prev = 1'b1;
        end
      end
    end
  end

  // Directed stimulus
  initial begin : stim
    int n;
    bit bad_t;
    bit bad_b;

    // Asynchronous reset with no clock edge
    #1 rst_n = 1'b0;
    #1;
    check("reset_tx", tx, 1);
    check("reset_busy", busy, 0);
    repeat (3) @(negedge clk);

    // 0xA5 requested on the first edge after reset release
    q.push_back('{8'hA5, 0});
    rst_n    = 1'b1;
    data     = 8'hA5;
    new_data = 1'b1;
    @(negedge clk);
    new_data = 1'b0;
    check("a5_start_latency", tx, 0);
    n = 0;
    while (busy === 1'b1 && n < 200) begin
      n++;
      @(negedge clk);
    end
    check("a5_busy_len", n, 40);
    check("a5_idle_tx", tx, 1);

    // 0x0F, then a 0x3C request at cycle 12 of the frame is ignored
    q.push_back('{8'h0F, 0});
    send_pulse(8'h0F);
    repeat (11) @(negedge clk);
    send_pulse(8'h3C);
    wait_idle("0f_done");
    bad_t = 1'b0;
    repeat (20) begin
      @(negedge clk);
      if (tx !== 1'b1) bad_t = 1'b1;
    end
    check("0f_line_idle", bad_t, 0);

    // block in IDLE: request for 0x55 refused
    block    = 1'b1;
    data     = 8'h55;
    new_data = 1'b1;
    @(negedge clk);
    bad_t = 1'b0;
    bad_b = 1'b0;
    repeat (20) begin
      @(negedge clk);
      if (tx !== 1'b1)   bad_t = 1'b1;
      if (busy !== 1'b1) bad_b = 1'b1;
    end
    check("block_idle_tx", bad_t, 0);
    check("block_idle_busy", bad_b, 0);
    new_data = 1'b0;
    @(negedge clk);
    block = 1'b0;
    @(negedge clk);
    check("block_release_busy", busy, 0);

    // block raised mid-frame: 0x81 completes intact
    q.push_back('{8'h81, 0});
    send_pulse(8'h81);
    repeat (15) @(negedge clk);
    block = 1'b1;
    repeat (40) @(negedge clk);
    check("block81_busy_held", busy, 1);
    check("block81_tx_idle", tx, 1);
    block = 1'b0;
    wait_idle("block81_done");

    // new_data held: 0x00 then 0xFF, start bits 41 cycles apart
    q.push_back('{8'h00, 0});
    q.push_back('{8'hFF, 41});
    data     = 8'h00;
    new_data = 1'b1;
    @(negedge clk);
    data = 8'hFF;
    n = 0;
    while (busy !== 1'b0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    @(negedge clk);
    new_data = 1'b0;
    check("held_second_busy", busy, 1);
    wait_idle("held_done");

    // Reset during data bit 3 of 0xF0, then 0xC3
    send_pulse(8'hF0);
    repeat (17) @(posedge clk);
    #1;
    check("f0_bit3_pre", tx, 0);
    rst_n = 1'b0;
    #1;
    check("midreset_tx", tx, 1);
    check("midreset_busy", busy, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (30) @(negedge clk);
    q.push_back('{8'hC3, 0});
    send_pulse(8'hC3);
    wait_idle("c3_done");

    repeat (10) @(negedge clk);
    check("scoreboard_empty", q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  // Watchdog
  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

endmodule : tb_uart_tx

// File: doc/uart_tx.md
UART_TX -- requirements
Module: uart_tx

Interface
REQ-001 SHALL provide parameter CLK_PER_BIT, default 868, meaning clk cycles per serial bit (115200 baud at 100 MHz); legal range >= 2.
REQ-002 SHALL provide port clk  input  1  100 MHz system clock; the block's only clock.
REQ-003 SHALL provide port rst_n  input  1  asynchronous, active-low reset.
REQ-004 SHALL provide port data  input  8  byte to transmit, sampled on acceptance.
REQ-005 SHALL provide port new_data  input  1  request to send data; single-cycle or held.
REQ-006 SHALL provide port block  input  1  flow-control hold; while high, no new frame is accepted.
REQ-007 SHALL provide port tx  output  1  serial line, idle high, drives usb_tx at top level.
REQ-008 SHALL provide port busy  output  1  high whenever a request would not be accepted.

Function
REQ-009 SHALL implement states IDLE, START, DATA, STOP.
REQ-010 SHALL accept a byte on the rising edge where state=IDLE, new_data=1, block=0; data latched to an internal shift register on that edge.
REQ-011 SHALL move IDLE->START on acceptance, with tx=0 and busy=1 registered from that same edge (one-cycle latency from request to start bit on line).
REQ-012 SHALL hold each bit (start, 8 data, stop) for exactly CLK_PER_BIT cycles, timed by a bit counter of width $clog2(CLK_PER_BIT) that reloads at each bit boundary.
REQ-013 SHALL send data LSB first in DATA, using a 3-bit index that goes 0..7 then exits to STOP; no wrap into a ninth bit.
REQ-014 SHALL drive tx=1 for the stop bit, then enter IDLE; IDLE lasts at least one cycle, so back-to-back frame period = 10*CLK_PER_BIT+1 cycles.
REQ-015 SHALL drive busy = (state!=IDLE) | block, registered; busy=0 only in IDLE with block=0.
REQ-016 SHALL ignore new_data while busy; no queuing, and no change to the frame in flight or its latched data.
REQ-017 SHALL not abort a frame in flight when block rises; block affects only acceptance in IDLE.
REQ-018 SHALL treat a change of data after acceptance as irrelevant to the current frame.
REQ-019 SHALL produce tx and busy directly from flops (glitch-free).

Reset
REQ-020 SHALL, on rst_n=0, asynchronously force state=IDLE, tx=1, busy=0, counters=0, shift register=0.
REQ-021 SHALL, on reset mid-frame, drive tx high immediately; the partial frame is not resumed.
REQ-022 SHALL, from the first clock edge after rst_n deasserts, accept a request under REQ-010.

Structure
REQ-023 SHALL take the state encoding (2 bits) and default CLK_PER_BIT from shared package uart_pkg, which the future uart_rx also uses.
REQ-024 SHALL keep the bit-period counter in-module; an optional sub-module uart_baud_counter (reload/tick) is the only natural split.

Verification (CLK_PER_BIT=4)
REQ-025 SHALL cover: assert rst_n=0 -> tx=1, busy=0 with no clock edge required.
REQ-026 SHALL cover: new_data pulse with data=0xA5 -> tx = 0, 1,0,1,0,0,1,0,1, 1, each bit 4 cycles; busy high 40 cycles, then low.
REQ-027 SHALL cover: send 0x0F, then pulse new_data with 0x3C at cycle 12 -> only the 0x0F frame appears; line idle afterward.
REQ-028 SHALL cover both block cases: block=1 in IDLE with 0x55 requested -> busy=1, tx stays 1; block raised mid-frame of 0x81 -> frame completes intact.
REQ-029 SHALL cover: new_data held high with 0x00 then 0xFF -> two frames whose start bits are exactly 41 cycles apart.
REQ-030 SHALL cover: rst_n pulsed low during data bit 3 -> tx=1, busy=0 at once; 0xC3 sent after release -> correct frame.
